// File: rtl/mm_cmd_master.sv
// Avalon-MM initiator: turns a valid/ready command stream into bus reads/writes,
// tracks pipelined reads and returns read data (or a timeout error) as a response stream.
`timescale 1ns/1ps
module mm_cmd_master #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [ADDR_W-1:0]                  cmd_address,
  input  logic [DATA_W-1:0]                  cmd_writedata,
  output logic                               rsp_valid,
  output logic [DATA_W-1:0]                  rsp_readdata,
  output logic                               rsp_error,
  output logic                               protocol_err,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               busy,
  output logic [ADDR_W-1:0]                  mm_address,
  output logic [DATA_W-1:0]                  mm_writedata,
  output logic                               mm_write,
  output logic                               mm_read,
  input  logic [DATA_W-1:0]                  mm_readdata,
  input  logic                               mm_readdatavalid,
  input  logic                               mm_waitrequest
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [OW-1:0] MAX_O      = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Command handshake: a command transfers on any cycle with cmd_valid && cmd_ready.
  // cmd_ready is registered and only ever high in IDLE with room for another read.
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_next;

  logic [TW-1:0]     timer, timer_next;
  logic [OW-1:0]     out_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              write_next, read_next, ready_next;
  logic              handshake, read_accept, rsp_normal, stray, timeout;

  assign handshake   = cmd_valid & cmd_ready;
  assign read_accept = (state == ISSUE) & ~mm_waitrequest & mm_read;
  // Reads accepted this cycle are not yet counted when qualifying readdatavalid.
  assign rsp_normal  = mm_readdatavalid & (outstanding != '0);
  assign stray       = mm_readdatavalid & (outstanding == '0);
  assign timeout     = (outstanding != '0) & ~mm_readdatavalid & (timer == TIMER_LAST);
  assign busy        = (state != IDLE) || (outstanding != '0);

  always_comb begin
    out_next = outstanding;
    if (read_accept && !(rsp_normal || timeout))
      out_next = outstanding + OW'(1);
    else if (!read_accept && (rsp_normal || timeout))
      out_next = outstanding - OW'(1);
  end

  always_comb begin
    timer_next = timer + TW'(1);
    if ((outstanding == '0) || mm_readdatavalid || timeout)
      timer_next = '0;
  end

  always_comb begin
    state_next = state;
    addr_next  = mm_address;
    wdata_next = mm_writedata;
    write_next = mm_write;
    read_next  = mm_read;
    ready_next = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = ISSUE;
          addr_next  = cmd_address;
          wdata_next = cmd_writedata;
          write_next = cmd_write;
          read_next  = ~cmd_write;
        end else begin
          ready_next = (out_next < MAX_O);
        end
      end
      ISSUE: begin
        // Strobe, address and data hold until the responder drops waitrequest.
        if (!mm_waitrequest) begin
          state_next = IDLE;
          write_next = 1'b0;
          read_next  = 1'b0;
          ready_next = (out_next < MAX_O);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      mm_address   <= '0;
      mm_writedata <= '0;
      mm_write     <= 1'b0;
      mm_read      <= 1'b0;
      outstanding  <= '0;
      timer        <= '0;
      rsp_valid    <= 1'b0;
      rsp_readdata <= '0;
      rsp_error    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_next;
      cmd_ready    <= ready_next;
      mm_address   <= addr_next;
      mm_writedata <= wdata_next;
      mm_write     <= write_next;
      mm_read      <= read_next;
      outstanding  <= out_next;
      timer        <= timer_next;
      rsp_valid    <= rsp_normal | timeout;
      rsp_error    <= timeout;
      if (rsp_normal)
        rsp_readdata <= mm_readdata;
      else if (timeout)
        rsp_readdata <= '1;
      protocol_err <= protocol_err | stray;
    end
  end

endmodule

// File: tb/tb_mm_cmd_master.sv
// Bench for mm_cmd_master: bench-driven responder, response scoreboard, per-feature tests.
`timescale 1ns/1ps
module tb_mm_cmd_master;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;
  localparam int TO   = 16;
  localparam int OW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_writedata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_readdata;
  logic          rsp_error;
  logic          protocol_err;
  logic [OW-1:0] outstanding;
  logic          busy;
  logic [AW-1:0] mm_address;
  logic [DW-1:0] mm_writedata;
  logic          mm_write;
  logic          mm_read;
  logic [DW-1:0] mm_readdata = '0;
  logic          mm_readdatavalid = 1'b0;
  logic          mm_waitrequest = 1'b0;

  int tests_run = 0;
  int failures  = 0;
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  mm_cmd_master #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .protocol_err(protocol_err), .outstanding(outstanding), .busy(busy),
    .mm_address(mm_address), .mm_writedata(mm_writedata),
    .mm_write(mm_write), .mm_read(mm_read),
    .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid),
    .mm_waitrequest(mm_waitrequest)
  );

  // Scoreboard: every response pulse is matched against the head of exp_q.
  always @(negedge clk) begin : monitor
    logic [DW:0] exp_v;
    if (rst_n && rsp_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got err=%b data=%h, required no response", rsp_error, rsp_readdata);
      end else begin
        exp_v = exp_q.pop_front();
        if ({rsp_error, rsp_readdata} !== exp_v) begin
          failures++;
          $display("FAIL rsp_data: got err=%b data=%h, required err=%b data=%h",
                   rsp_error, rsp_readdata, exp_v[DW], exp_v[DW-1:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      tests_run++; failures++;
      $display("FAIL cmd_handshake: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] d);
    mm_readdatavalid = 1'b1;
    mm_readdata = d;
    exp_q.push_back({1'b0, d});
    @(negedge clk);
    mm_readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({cmd_ready, mm_write, mm_read, rsp_valid, rsp_error, protocol_err, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {cmd_ready, mm_write, mm_read, rsp_valid, rsp_error, protocol_err, busy});
    end
    tests_run++;
    if (mm_address !== '0 || mm_writedata !== '0 || rsp_readdata !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0", mm_address, mm_writedata, rsp_readdata);
    end
    tests_run++;
    if (outstanding !== '0) begin
      failures++;
      $display("FAIL reset_outstanding: got %0d, required 0", outstanding);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    mm_waitrequest = 1'b0;
    send_cmd(1'b1, 32'h0, 32'h05);
    tests_run++;
    if ({mm_write, mm_read, cmd_ready} !== 3'b100 || mm_address !== 32'h0 || mm_writedata !== 32'h05) begin
      failures++;
      $display("FAIL write_issue: got wr/rd/rdy=%b addr=%h data=%h, required 100 addr=0 data=5",
               {mm_write, mm_read, cmd_ready}, mm_address, mm_writedata);
    end
    @(negedge clk);
    tests_run++;
    if ({mm_write, cmd_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL write_done: got wr/rdy/busy=%b, required 010", {mm_write, cmd_ready, busy});
    end
  endtask

  task automatic test_read();
    send_cmd(1'b0, 32'h4, 32'h0);
    tests_run++;
    if ({mm_read, mm_write} !== 2'b10 || mm_address !== 32'h4) begin
      failures++;
      $display("FAIL read_issue: got rd/wr=%b addr=%h, required 10 addr=4", {mm_read, mm_write}, mm_address);
    end
    @(negedge clk);
    tests_run++;
    if (outstanding !== OW'(1) || mm_read !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL read_inflight: got out=%0d rd=%b busy=%b, required 1 0 1", outstanding, mm_read, busy);
    end
    respond(32'h2A);
    tests_run++;
    if (outstanding !== '0) begin
      failures++;
      $display("FAIL read_out_after: got %0d, required 0", outstanding);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_single_pulse: got rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_waitrequest();
    mm_waitrequest = 1'b1;
    send_cmd(1'b1, 32'h8, 32'hA5A5_0008);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (mm_write !== 1'b1 || mm_address !== 32'h8 || mm_writedata !== 32'hA5A5_0008 || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold[%0d]: got wr=%b addr=%h data=%h rdy=%b, required 1 8 a5a50008 0",
                 i, mm_write, mm_address, mm_writedata, cmd_ready);
      end
      @(negedge clk);
    end
    tests_run++;
    if (mm_write !== 1'b1) begin
      failures++;
      $display("FAIL wait_cycle8: got wr=%b, required 1", mm_write);
    end
    mm_waitrequest = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mm_write, cmd_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL wait_release: got wr/rdy/busy=%b, required 010", {mm_write, cmd_ready, busy});
    end
  endtask

  task automatic test_max_outstanding();
    logic [DW-1:0] vals[4];
    logic hs;
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 32'h10 + 32'(4 * i), 32'h0);
    @(negedge clk);
    tests_run++;
    if (outstanding !== OW'(4) || cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL max_full: got out=%0d rdy=%b, required 4 0", outstanding, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h20; cmd_writedata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (cmd_ready !== 1'b0 || mm_read !== 1'b0) begin
        failures++;
        $display("FAIL max_blocked[%0d]: got rdy=%b rd=%b, required 0 0", i, cmd_ready, mm_read);
      end
    end
    // Fifth read stays offered; it is released as soon as a slot frees up.
    for (int i = 0; i < 4; i++) begin
      mm_readdatavalid = 1'b1;
      mm_readdata = vals[i];
      exp_q.push_back({1'b0, vals[i]});
      hs = cmd_valid && cmd_ready;
      @(negedge clk);
      if (hs) cmd_valid = 1'b0;
    end
    mm_readdatavalid = 1'b0;
    cmd_valid = 1'b0;
    tests_run++;
    if (outstanding !== OW'(1)) begin
      failures++;
      $display("FAIL max_fifth_inflight: got out=%0d, required 1", outstanding);
    end
    respond(32'h55);
    tests_run++;
    if (outstanding !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL max_drained: got out=%0d busy=%b, required 0 0", outstanding, busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_q.push_back({1'b1, {DW{1'b1}}});
    send_cmd(1'b0, 32'h30, 32'h0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n !== TO + 1) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles after accept, required %0d", n, TO + 1);
    end
    tests_run++;
    if (outstanding !== '0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: got out=%0d perr=%b, required 0 0", outstanding, protocol_err);
    end
    mm_readdatavalid = 1'b1;
    mm_readdata = 32'h99;
    @(negedge clk);
    mm_readdatavalid = 1'b0;
    tests_run++;
    if (protocol_err !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_rdv: got perr=%b rsp_valid=%b, required 1 0", protocol_err, rsp_valid);
    end
    @(negedge clk);
    tests_run++;
    if (protocol_err !== 1'b1) begin
      failures++;
      $display("FAIL perr_sticky: got %b, required 1", protocol_err);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b0, 32'h40, 32'h0);
    send_cmd(1'b0, 32'h44, 32'h0);
    @(negedge clk);
    tests_run++;
    if (outstanding !== OW'(2)) begin
      failures++;
      $display("FAIL rmid_pre: got out=%0d, required 2", outstanding);
    end
    mm_waitrequest = 1'b1;
    send_cmd(1'b1, 32'h8, 32'h1234);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cmd_ready, mm_write, mm_read, protocol_err, busy} !== 5'b0 || outstanding !== '0 || mm_address !== '0) begin
      failures++;
      $display("FAIL rmid_async: got rdy/wr/rd/perr/busy=%b out=%0d addr=%h, required 0",
               {cmd_ready, mm_write, mm_read, protocol_err, busy}, outstanding, mm_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mm_waitrequest = 1'b0;
    @(negedge clk);
    send_cmd(1'b0, 32'h4, 32'h0);
    @(negedge clk);
    respond(32'h77);
    tests_run++;
    if (outstanding !== '0 || protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after: got out=%0d perr=%b, required 0 0", outstanding, protocol_err);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_waitrequest();
    test_max_outstanding();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rsp_missing: got %0d unanswered, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
